// File: rtl/fs4_serial_pkg.sv
// rtl/fs4_serial_pkg.sv - shared state encoding and sizing helpers for the fs4_serial bit-serial subtractor
package fs4_serial_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_CALC = 2'd1,
        FS_HOLD = 2'd2
    } fs_state_e;

    localparam int FS_DEFAULT_WIDTH = 4;

    function automatic int fs_cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/fs4_serial_fs1.sv
// rtl/fs4_serial_fs1.sv - combinational 1-bit full subtractor cell (d = a - b - bi)
module fs1 (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/fs4_serial.sv
// rtl/fs4_serial.sv - bit-serial WIDTH-bit subtractor, LSB first; FS4_SERIAL_OVF_EN adds signed overflow output ovf
module fs4_serial
    import fs4_serial_pkg::*;
#(
    parameter int WIDTH = FS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bo,
`ifdef FS4_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CW = fs_cnt_width(WIDTH);

    fs_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bo_q, bo_d;
    logic             diff, br_next;
    logic [WIDTH-1:0] full_res;

    fs1 u_fs1 (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .bi (br_q),
        .d  (diff),
        .bo (br_next)
    );

    // The new bit lands at the MSB; the LSB falls out only once it is final.
    assign full_res = {diff, res_q};

`ifdef FS4_SERIAL_OVF_EN
    logic ovf_q, ovf_d;
    assign ovf = ovf_q;
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bo_d    = bo_q;
`ifdef FS4_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            FS_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bi;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = FS_CALC;
                end
            end
            FS_CALC: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_next;
                res_d  = full_res[WIDTH-1:1];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    d_d     = full_res;
                    bo_d    = br_next;
                    cnt_d   = '0;
                    state_d = FS_HOLD;
`ifdef FS4_SERIAL_OVF_EN
                    // On the last edge bit 0 of each shifter is the operand sign bit.
                    ovf_d = (a_sh_q[0] ^ b_sh_q[0]) & (diff ^ a_sh_q[0]);
`endif
                end
            end
            FS_HOLD: begin
                if (out_ready) begin
                    state_d = FS_IDLE;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
`ifdef FS4_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bo_q    <= bo_d;
`ifdef FS4_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == FS_IDLE);
    assign busy      = (state_q == FS_CALC);
    assign out_valid = (state_q == FS_HOLD);
    assign d         = d_q;
    assign bo        = bo_q;

endmodule
